cpc_ram_banker: RTL
===================

CPC_RAM_BANKER -- requirements
Module: cpc_ram_banker

Interface
REQ-001 SHALL have parameter BANK_BITS, default 3, giving the number of 64K-bank select bits; legal range 3..6, so 512K to 4M.
REQ-002 SHALL have parameter EXT_BITS, fixed at BANK_BITS-3, giving the count of extended bank bits taken from the I/O port address.
REQ-003 SHALL have port clk, input, 1 bit: CPC 4 MHz bus clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_b, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port busreset_b, input, 1 bit: expansion-bus reset, active-low, sampled synchronously.
REQ-006 SHALL have port adr, input, 2 bits: CPU A15..A14.
REQ-007 SHALL have port adrio, input, max(EXT_BITS,1) bits: CPU A8 upward, used for extended bank bits.
REQ-008 SHALL have ports iorq_b, mreq_b, wr_b, ramrd_b, each input, 1 bit: Z80/CPC bus strobes, active-low.
REQ-009 SHALL have port data, input, 8 bits: CPU data bus.
REQ-010 SHALL have port ramadrhi, output, BANK_BITS+2 bits: SRAM high address, {bank, block}.
REQ-011 SHALL have ports ramcs_b, ramoe_b, ramwe_b, each output, 1 bit: SRAM chip select, output enable and write enable, all active-low.
REQ-012 SHALL have port ramdis, output, 1 bit: disables CPC internal RAM when high.
REQ-013 SHALL have port cfg_stb, output, 1 bit: one-clk pulse when the bank register loads.

Function
REQ-014 SHALL decode a config write when iorq_b=0, wr_b=0, A15=0 and data[7:6]=11.
REQ-015 SHALL run the config FSM with states CIDLE, CHOLD:
- CIDLE: decode true at a clk edge -> load bank register and go to CHOLD.
- CHOLD: return to CIDLE at the first edge with iorq_b=1.
REQ-016 SHALL therefore load the bank register exactly once per I/O cycle, however many clks the write lasts.
REQ-017 SHALL load the bank register as follows:
- mode[2:0] <= data[2:0]
- bank[2:0] <= data[5:3]
- bank[BANK_BITS-1:3] <= bitwise NOT of adrio[EXT_BITS-1:0], so port &7Fxx gives extended bits 0.
REQ-018 SHALL pulse cfg_stb high for exactly the clk following a load.
REQ-019 SHALL run the memory FSM with states MIDLE, MACT:
- MIDLE: mreq_b=0 at a clk edge -> latch adr into adr_q, compute the mapping, go to MACT.
- MACT: return to MIDLE at the first edge with mreq_b=1.
REQ-020 SHALL keep the mapping constant throughout MACT; mid-cycle changes of adr or of the bank register have no effect until the next MIDLE->MACT entry.
REQ-021 SHALL compute the mapping (blk = adr_q) per mode:
- mode 0: no external access.
- mode 1: blk 3 -> {bank, 3}; otherwise none.
- mode 2: every block -> {bank, blk}.
- mode 3: blk 3 -> {bank, 3}; otherwise none.
- modes 4-7: blk 1 -> {bank, mode-4}; otherwise none.
REQ-022 SHALL, on a mapped access in MACT, drive ramcs_b=0, ramdis=1 and ramadrhi as per REQ-021.
REQ-023 SHALL, when the access is unmapped or the FSM is in MIDLE, drive ramcs_b=1, ramdis=0 and ramadrhi={BANK_BITS+2{0}}.
REQ-024 SHALL drive ramoe_b = ramrd_b OR ramcs_b and ramwe_b = wr_b OR ramcs_b, combinationally.
REQ-025 SHALL give one-clk latency from the first clk edge with mreq_b=0 to ramcs_b assertion, and deassert ramcs_b on the edge where mreq_b=1 is seen.
REQ-026 SHALL apply a config load and a memory-cycle entry on the same edge as follows: the memory access uses the previous register value and the new value applies from the next cycle.
REQ-027 SHALL, when busreset_b=0 at a clk edge, clear the bank register and mode to 0 and force both FSMs to their idle states; this takes priority over a simultaneous config write.

Reset
REQ-028 SHALL, with reset_b=0, asynchronously hold bank=0, mode=0, CIDLE, MIDLE, adr_q=0 and cfg_stb=0.
REQ-029 SHALL hold these outputs while reset_b=0: ramcs_b=1, ramdis=0, ramadrhi=0, ramoe_b=1, ramwe_b=1.
REQ-030 SHALL leave a memory cycle in progress at reset abandoned; the first access after release starts from MIDLE.
REQ-031 SHALL operate normally from the first clk edge after reset_b deasserts.

Verification
REQ-032 SHALL cover: BANK_BITS=3, OUT &7F,&C2, read &0000..&FFFF -> ramadrhi = 0..3 in blocks 0..3, ramcs_b=0 one clk after mreq_b falls, ramdis=1.
REQ-033 SHALL cover: BANK_BITS=5, OUT &7D,&FC (adrio=01, so ext=10), read &4000 -> ramadrhi={10111,00}; read &8000 -> ramcs_b=1, ramdis=0.
REQ-034 SHALL cover: a 6-clk I/O write with data &C9 -> exactly one cfg_stb pulse; mode=1, bank=1; read &C000 -> ramadrhi=00111.
REQ-035 SHALL cover: a config write to &C4 landing on the same edge as an mreq_b fall at &4000 with prior mode 0 -> that access internal (ramcs_b=1); next access to &4000 -> ramadrhi=00000.
REQ-036 SHALL cover: busreset_b pulsed low during MACT with mode 2 active -> ramcs_b=1 next edge, bank=0, mode=0; a simultaneous config write is ignored.
REQ-037 SHALL cover: reset_b asserted mid-cycle -> outputs go immediately to REQ-029 values; after release, an OUT &7F,&C2 then read &0000 maps normally.

Source files
------------

// File: rtl/cpc_ram_banker.sv
// CPC expansion RAM banker: decodes bank-select OUTs and maps
// Z80 memory cycles onto an external SRAM with 64K banks.
module cpc_ram_banker #(
    parameter int BANK_BITS = 3,
    parameter int EXT_BITS  = BANK_BITS - 3,
    localparam int AW       = (EXT_BITS > 0) ? EXT_BITS : 1
) (
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic                 busreset_b,
    input  logic [1:0]           adr,
    input  logic [AW-1:0]        adrio,
    input  logic                 iorq_b,
    input  logic                 mreq_b,
    input  logic                 wr_b,
    input  logic                 ramrd_b,
    input  logic [7:0]           data,
    output logic [BANK_BITS+1:0] ramadrhi,
    output logic                 ramcs_b,
    output logic                 ramoe_b,
    output logic                 ramwe_b,
    output logic                 ramdis,
    output logic                 cfg_stb
);

    typedef enum logic {CIDLE, CHOLD} cstate_t;
    typedef enum logic {MIDLE, MACT} mstate_t;

    cstate_t              cst_q, cst_d;
    mstate_t              mst_q, mst_d;
    logic [BANK_BITS-1:0] bank_q, bank_d;
    logic [2:0]           mode_q, mode_d;
    logic [1:0]           adr_q, adr_d;
    logic [BANK_BITS-1:0] mbank_q, mbank_d;
    logic [2:0]           mmode_q, mmode_d;
    logic                 cfg_stb_q, cfg_stb_d;

    logic [BANK_BITS-1:0] load_bank;
    logic                 cfg_wr;
    logic                 hit;
    logic                 act;
    logic [1:0]           blk;

    // Extended bank bits are inverted so port &7Fxx selects the low 512K.
    generate
        if (EXT_BITS > 0) begin : g_ext
            assign load_bank = {~adrio, data[5:3]};
        end else begin : g_noext
            logic adrio_unused;
            assign adrio_unused = ^adrio;
            assign load_bank    = data[5:3];
        end
    endgenerate

    assign cfg_wr = !iorq_b && !wr_b && !adr[1] && (data[7:6] == 2'b11);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cst_q     <= CIDLE;
            mst_q     <= MIDLE;
            bank_q    <= '0;
            mode_q    <= '0;
            adr_q     <= '0;
            mbank_q   <= '0;
            mmode_q   <= '0;
            cfg_stb_q <= 1'b0;
        end else begin
            cst_q     <= cst_d;
            mst_q     <= mst_d;
            bank_q    <= bank_d;
            mode_q    <= mode_d;
            adr_q     <= adr_d;
            mbank_q   <= mbank_d;
            mmode_q   <= mmode_d;
            cfg_stb_q <= cfg_stb_d;
        end
    end

    // The memory cycle snapshots the bank register before any same-edge load.
    always_comb begin
        cst_d     = cst_q;
        mst_d     = mst_q;
        bank_d    = bank_q;
        mode_d    = mode_q;
        adr_d     = adr_q;
        mbank_d   = mbank_q;
        mmode_d   = mmode_q;
        cfg_stb_d = 1'b0;
        if (!busreset_b) begin
            cst_d  = CIDLE;
            mst_d  = MIDLE;
            bank_d = '0;
            mode_d = '0;
        end else begin
            unique case (mst_q)
                MIDLE: begin
                    if (!mreq_b) begin
                        mst_d   = MACT;
                        adr_d   = adr;
                        mbank_d = bank_q;
                        mmode_d = mode_q;
                    end
                end
                MACT: begin
                    if (mreq_b) mst_d = MIDLE;
                end
            endcase
            unique case (cst_q)
                CIDLE: begin
                    if (cfg_wr) begin
                        cst_d     = CHOLD;
                        bank_d    = load_bank;
                        mode_d    = data[2:0];
                        cfg_stb_d = 1'b1;
                    end
                end
                CHOLD: begin
                    if (iorq_b) cst_d = CIDLE;
                end
            endcase
        end
    end

    always_comb begin
        hit = 1'b0;
        blk = adr_q;
        case (mmode_q)
            3'd0:       hit = 1'b0;
            3'd1, 3'd3: hit = (adr_q == 2'd3);
            3'd2:       hit = 1'b1;
            default: begin
                hit = (adr_q == 2'd1);
                blk = mmode_q[1:0];
            end
        endcase
    end

    assign act      = (mst_q == MACT) && hit;
    assign ramcs_b  = !act;
    assign ramdis   = act;
    assign ramadrhi = act ? {mbank_q, blk} : '0;
    assign ramoe_b  = ramrd_b | ramcs_b;
    assign ramwe_b  = wr_b | ramcs_b;
    assign cfg_stb  = cfg_stb_q;

endmodule
